// File: rtl/av_pmod_output.sv
// av_pmod_output
// Audio/video pin stage for the TinyVGA PMOD plus one PDM audio pin.
// Wider colour is reduced to 2 bits per channel with a 2x2 ordered dither.
// Colour is blanked outside the visible area. A multi-bit PCM sample becomes
// a first-order sigma-delta bit stream. Every pin passes through the same
// PIPE_STAGES-deep register chain, so video and audio latency are fixed.
//
// Ports
//   clk, reset     : system clock, synchronous active-high reset
//   rgb            : {r,g,b}, COLOR_BITS each, MSB-first
//   active         : visible-pixel qualifier (drives blanking and parity)
//   hsync, vsync   : syncs, passed through without blanking or inversion
//   new_frame      : one-cycle frame-start pulse, clears row parity
//   dither_en      : 1 = ordered dither, 0 = truncate to top 2 bits
//   audio_sample   : unsigned PCM, loaded when audio_valid is high
//   uo_out         : {hsync,b0,g0,r0,vsync,b1,g1,r1}
//   uio_out        : [7] PDM audio, [6:0] tied low
//   uio_oe         : constant 8'h80

// One colour channel: 2-bit level from a COLOR_BITS-wide input.
module av_pmod_dither #(
    parameter int COLOR_BITS = 2
) (
    input  logic [COLOR_BITS-1:0] chan,
    input  logic                  dither_en,
    input  logic [1:0]            thresh,
    output logic [1:0]            level
);
    logic [1:0] top;
    assign top = chan[COLOR_BITS-1 -: 2];

    generate
        if (COLOR_BITS > 2) begin : g_dither
            localparam int E = COLOR_BITS - 2;
            logic [1:0] frac;
            // Left-align the E leftover bits into a 2-bit fraction; with E=1
            // the missing low bit is zero-filled.
            assign frac = 2'({chan[E-1:0], 2'b00} >> E);

            always_comb begin
                level = top;
                // Round up when the fraction beats this cell's threshold,
                // but never past the top code.
                if (dither_en && (frac > thresh) && (top != 2'd3))
                    level = top + 2'd1;
            end
        end else begin : g_pass
            assign level = top;
            logic unused_ok;
            assign unused_ok = ^{dither_en, thresh};
        end
    endgenerate
endmodule

module av_pmod_output #(
    parameter int COLOR_BITS  = 2,
    parameter int AUDIO_BITS  = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3*COLOR_BITS-1:0] rgb,
    input  logic                    active,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    new_frame,
    input  logic                    dither_en,
    input  logic [AUDIO_BITS-1:0]   audio_sample,
    input  logic                    audio_valid,
    output logic [7:0]              uo_out,
    output logic [7:0]              uio_out,
    output logic [7:0]              uio_oe
);
    typedef struct packed {
        logic [7:0] pins;
        logic       pdm;
    } pin_word_t;

    // ---------------- position parity ----------------
    logic xp, yp, active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xp       <= 1'b0;
            yp       <= 1'b0;
            active_q <= 1'b0;
        end else begin
            active_q <= active;
            xp       <= active ? ~xp : 1'b0;
            // Frame start beats the end-of-line toggle when both land together.
            if (new_frame)
                yp <= 1'b0;
            else if (active_q && !active)
                yp <= ~yp;
        end
    end

    // 2x2 Bayer thresholds indexed by (xp,yp); uses pre-update parity.
    logic [1:0] thresh;
    always_comb begin
        case ({xp, yp})
            2'b00:   thresh = 2'd0;
            2'b10:   thresh = 2'd2;
            2'b01:   thresh = 2'd3;
            default: thresh = 2'd1;
        endcase
    end

    // ---------------- colour channels ----------------
    // index 0 = b, 1 = g, 2 = r (matches {r,g,b} packing of rgb)
    logic [2:0][1:0] level;
    logic [2:0][1:0] level_b;

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        av_pmod_dither #(.COLOR_BITS(COLOR_BITS)) u_dither (
            .chan      (rgb[ch*COLOR_BITS +: COLOR_BITS]),
            .dither_en (dither_en),
            .thresh    (thresh),
            .level     (level[ch])
        );
    end

    assign level_b = active ? level : '0;

    logic [7:0] mapped;
    assign mapped = {hsync, level_b[0][0], level_b[1][0], level_b[2][0],
                     vsync, level_b[0][1], level_b[1][1], level_b[2][1]};

    // ---------------- sigma-delta audio ----------------
    logic [AUDIO_BITS-1:0] sample_q, acc;
    logic [AUDIO_BITS:0]   sum;
    logic                  pdm_bit;

    // The carry out of the wrapping accumulator is the 1-bit output.
    assign sum = {1'b0, acc} + {1'b0, sample_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            acc      <= '0;
            pdm_bit  <= 1'b0;
        end else begin
            if (audio_valid)
                sample_q <= audio_sample;
            acc     <= sum[AUDIO_BITS-1:0];
            pdm_bit <= sum[AUDIO_BITS];
        end
    end

    // ---------------- output retiming ----------------
    pin_word_t stage0;
    pin_word_t pipe_q [PIPE_STAGES];

    assign stage0 = '{pins: mapped, pdm: pdm_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_STAGES; i++)
                pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage0;
            for (int i = 1; i < PIPE_STAGES; i++)
                pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign uo_out  = pipe_q[PIPE_STAGES-1].pins;
    assign uio_out = {pipe_q[PIPE_STAGES-1].pdm, 7'b0};
    assign uio_oe  = 8'h80;
endmodule

// File: tb/tb_av_pmod_output.sv
module tb_av_pmod_output;
    localparam int LAT  = 3;   // dut latency
    localparam int LAT2 = 1;   // dut2 latency

    typedef struct { int due; logic [7:0] val; } exp_t;
    typedef struct {
        logic [11:0] rgb; logic [5:0] rgb2;
        logic act, hs, vs, nf, den;
        logic [7:0] e, e2;
    } vst_t;
    typedef struct { logic rst, av; logic [7:0] smp; } aop_t;

    logic        clk, reset, active, hsync, vsync, new_frame, dither_en, audio_valid;
    logic [11:0] rgb;
    logic [5:0]  rgb2;
    logic [7:0]  audio_sample;
    logic [3:0]  audio_sample2;
    logic [7:0]  uo_out, uio_out, uio_oe, uo2, uio2, oe2;

    int   total, bad, cyc;
    exp_t vq[$], vq2[$], aq[$];
    vst_t vs[$];

    av_pmod_output #(.COLOR_BITS(4), .AUDIO_BITS(8), .PIPE_STAGES(LAT)) dut (
        .clk(clk), .reset(reset), .rgb(rgb), .active(active), .hsync(hsync),
        .vsync(vsync), .new_frame(new_frame), .dither_en(dither_en),
        .audio_sample(audio_sample), .audio_valid(audio_valid),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe));

    av_pmod_output #(.COLOR_BITS(2), .AUDIO_BITS(4), .PIPE_STAGES(LAT2)) dut2 (
        .clk(clk), .reset(reset), .rgb(rgb2), .active(active), .hsync(hsync),
        .vsync(vsync), .new_frame(new_frame), .dither_en(dither_en),
        .audio_sample(audio_sample2), .audio_valid(audio_valid),
        .uo_out(uo2), .uio_out(uio2), .uio_oe(oe2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        reset = 0; active = 0; hsync = 0; vsync = 0; new_frame = 0;
        dither_en = 0; audio_valid = 0; audio_sample = 0;
        rgb = 0; rgb2 = 0;
    endtask

    task automatic push_v(input logic [7:0] e, input logic [7:0] e2);
        exp_t t;
        t.due = cyc + LAT;  t.val = e;  vq.push_back(t);
        t.due = cyc + LAT2; t.val = e2; vq2.push_back(t);
    endtask

    task automatic push_a(input int due, input logic [7:0] v);
        exp_t t;
        t.due = due; t.val = v; aq.push_back(t);
    endtask

    task automatic vadd(input logic [11:0] r12, input logic [5:0] r6,
                        input logic act, input logic hs, input logic vsn,
                        input logic nf, input logic den,
                        input logic [7:0] e, input logic [7:0] e2);
        vst_t s;
        s.rgb = r12; s.rgb2 = r6; s.act = act; s.hs = hs; s.vs = vsn;
        s.nf = nf; s.den = den; s.e = e; s.e2 = e2;
        vs.push_back(s);
    endtask

    task automatic vdrive(input vst_t s);
        reset = 0; rgb = s.rgb; rgb2 = s.rgb2; active = s.act; hsync = s.hs;
        vsync = s.vs; new_frame = s.nf; dither_en = s.den; audio_valid = 0;
        push_v(s.e, s.e2);
    endtask

    // Two 2-pixel lines of red r (g=b=0); nf2 pulses new_frame on the
    // blanking cycle that ends the first line. dut2 sees red=01 throughout.
    task automatic line_seq(input logic [3:0] r, input logic den, input logic nf2,
                            input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
        logic [11:0] c;
        c = {r, 8'h00};
        vadd(c, 6'b01_00_00, 0, 0, 0, 1,   den, 8'h00, 8'h00);
        vadd(c, 6'b01_00_00, 1, 0, 0, 0,   den, p0,    8'h10);
        vadd(c, 6'b01_00_00, 1, 0, 0, 0,   den, p1,    8'h10);
        vadd(c, 6'b01_00_00, 0, 0, 0, nf2, den, 8'h00, 8'h00);
        vadd(c, 6'b01_00_00, 1, 0, 0, 0,   den, p2,    8'h10);
        vadd(c, 6'b01_00_00, 1, 0, 0, 0,   den, p3,    8'h10);
        vadd(c, 6'b01_00_00, 0, 0, 0, 0,   den, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            total += 4;
            if (uo_out !== 8'h00) begin bad++; $display("FAIL reset uo_out got=%02h want=00", uo_out); end
            if (uio_out !== 8'h00) begin bad++; $display("FAIL reset uio_out got=%02h want=00", uio_out); end
            if (uio_oe !== 8'h80) begin bad++; $display("FAIL reset uio_oe got=%02h want=80", uio_oe); end
            if (uo2 !== 8'h00) begin bad++; $display("FAIL reset uo2 got=%02h want=00", uo2); end
        end
        idle();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_pinout();
        exp_t e;
        vs.delete();
        vadd(12'h000, 6'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        vadd(12'b1000_0100_1100, 6'b10_01_11, 1, 1, 0, 0, 1, 8'he5, 8'he5);
        vadd(12'hfff, 6'h3f, 0, 0, 1, 0, 1, 8'h08, 8'h08);
        vadd(12'hfff, 6'h3f, 0, 1, 1, 0, 1, 8'h88, 8'h88);
        vadd(12'hfff, 6'h3f, 1, 0, 1, 0, 0, 8'h7f, 8'h7f);
        vadd(12'h000, 6'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < vs.size() + LAT + 1; i++) begin
            if (i < vs.size()) vdrive(vs[i]); else idle();
            step();
            total += 2;
            if (uio_oe !== 8'h80) begin bad++; $display("FAIL pinout uio_oe got=%02h want=80", uio_oe); end
            if (oe2 !== 8'h80) begin bad++; $display("FAIL pinout oe2 got=%02h want=80", oe2); end
            while (vq.size() > 0 && vq[0].due == cyc) begin
                e = vq.pop_front(); total++;
                if (uo_out !== e.val) begin bad++; $display("FAIL pinout uo_out cyc=%0d got=%02h want=%02h", cyc, uo_out, e.val); end
            end
            while (vq2.size() > 0 && vq2[0].due == cyc) begin
                e = vq2.pop_front(); total++;
                if (uo2 !== e.val) begin bad++; $display("FAIL pinout uo2 cyc=%0d got=%02h want=%02h", cyc, uo2, e.val); end
            end
        end
    endtask

    task automatic test_dither();
        exp_t e;
        vs.delete();
        line_seq(4'b0110, 1, 0, 8'h01, 8'h10, 8'h10, 8'h01);
        line_seq(4'b1111, 1, 0, 8'h11, 8'h11, 8'h11, 8'h11);
        line_seq(4'b0110, 0, 0, 8'h10, 8'h10, 8'h10, 8'h10);
        for (int i = 0; i < vs.size() + LAT + 1; i++) begin
            if (i < vs.size()) vdrive(vs[i]); else idle();
            step();
            while (vq.size() > 0 && vq[0].due == cyc) begin
                e = vq.pop_front(); total++;
                if (uo_out !== e.val) begin bad++; $display("FAIL dither uo_out cyc=%0d got=%02h want=%02h", cyc, uo_out, e.val); end
            end
            while (vq2.size() > 0 && vq2[0].due == cyc) begin
                e = vq2.pop_front(); total++;
                if (uo2 !== e.val) begin bad++; $display("FAIL dither uo2 cyc=%0d got=%02h want=%02h", cyc, uo2, e.val); end
            end
        end
    endtask

    task automatic test_parity_reset();
        exp_t e;
        vs.delete();
        line_seq(4'b0110, 1, 1, 8'h01, 8'h10, 8'h01, 8'h10);
        for (int i = 0; i < vs.size() + LAT + 1; i++) begin
            if (i < vs.size()) vdrive(vs[i]); else idle();
            step();
            while (vq.size() > 0 && vq[0].due == cyc) begin
                e = vq.pop_front(); total++;
                if (uo_out !== e.val) begin bad++; $display("FAIL parity uo_out cyc=%0d got=%02h want=%02h", cyc, uo_out, e.val); end
            end
            while (vq2.size() > 0 && vq2[0].due == cyc) begin
                e = vq2.pop_front(); total++;
                if (uo2 !== e.val) begin bad++; $display("FAIL parity uo2 cyc=%0d got=%02h want=%02h", cyc, uo2, e.val); end
            end
        end
    endtask

    task automatic test_audio();
        aop_t ops[$];
        aop_t o;
        exp_t e;
        logic [7:0] acc_m, smp_m, ld [4];
        logic [8:0] sum;
        int len [4];
        ld[0] = 8'd128; ld[1] = 8'd64; ld[2] = 8'd0; ld[3] = 8'd255;
        len[0] = 12; len[1] = 16; len[2] = 12; len[3] = 20;
        o.rst = 1; o.av = 0; o.smp = 0; ops.push_back(o);
        o.rst = 0; ops.push_back(o); ops.push_back(o);
        for (int k = 0; k < 4; k++) begin
            o.av = 1; o.smp = ld[k]; ops.push_back(o);
            o.av = 0;
            for (int j = 1; j < len[k]; j++) ops.push_back(o);
        end
        acc_m = 0; smp_m = 0;
        for (int i = 0; i < ops.size() + LAT + 2; i++) begin
            idle();
            if (i < ops.size()) begin
                reset = ops[i].rst; audio_valid = ops[i].av; audio_sample = ops[i].smp;
                if (ops[i].rst) begin
                    acc_m = 0; smp_m = 0;
                    push_a(cyc + 1 + LAT, 8'h00);
                end else begin
                    sum = {1'b0, acc_m} + {1'b0, smp_m};
                    push_a(cyc + 1 + LAT, {sum[8], 7'b0});
                    acc_m = sum[7:0];
                    if (ops[i].av) smp_m = ops[i].smp;
                end
            end
            step();
            while (aq.size() > 0 && aq[0].due == cyc) begin
                e = aq.pop_front(); total++;
                if (uio_out !== e.val) begin bad++; $display("FAIL audio uio_out cyc=%0d got=%02h want=%02h", cyc, uio_out, e.val); end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int j = 0; j < 24; j++) begin
            idle();
            reset = (j == 4);
            active = 1; hsync = 1; rgb = 12'hfff; rgb2 = 6'h3f; dither_en = 1;
            audio_valid = (j == 0) || (j == 4) || (j == 7);
            audio_sample = 8'd128;
            if (j >= 16) idle();
            if (j == 4) begin
                push_a(cyc + 1, 8'h00);
                for (int k = 1; k <= 3; k++) begin
                    e.due = cyc + k; e.val = 8'h00; vq.push_back(e);
                end
                e.due = cyc + 1; e.val = 8'h00; vq2.push_back(e);
                for (int k = 2; k <= 7; k++) push_a(cyc + k, 8'h00);
            end
            if (j > 4 && j < 16) push_v(8'hf7, 8'hf7);
            // acc restarts at 0: sums 128, 256 (carry), 384, 512 (carry), ...
            if (j == 7) begin
                push_a(cyc + 5, 8'h00);
                push_a(cyc + 6, 8'h80);
                push_a(cyc + 7, 8'h00);
                push_a(cyc + 8, 8'h80);
                push_a(cyc + 9, 8'h00);
            end
            step();
            while (vq.size() > 0 && vq[0].due == cyc) begin
                e = vq.pop_front(); total++;
                if (uo_out !== e.val) begin bad++; $display("FAIL rst_mid uo_out cyc=%0d got=%02h want=%02h", cyc, uo_out, e.val); end
            end
            while (vq2.size() > 0 && vq2[0].due == cyc) begin
                e = vq2.pop_front(); total++;
                if (uo2 !== e.val) begin bad++; $display("FAIL rst_mid uo2 cyc=%0d got=%02h want=%02h", cyc, uo2, e.val); end
            end
            while (aq.size() > 0 && aq[0].due == cyc) begin
                e = aq.pop_front(); total++;
                if (uio_out !== e.val) begin bad++; $display("FAIL rst_mid uio_out cyc=%0d got=%02h want=%02h", cyc, uio_out, e.val); end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        audio_sample2 = 4'h0;
        idle();
        test_reset();
        test_pinout();
        test_dither();
        test_parity_reset();
        test_audio();
        test_reset_mid();
        total++;
        if (vq.size() + vq2.size() + aq.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d want=0", vq.size() + vq2.size() + aq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/av_pmod_output.md
# av_pmod_output

Parametrised audio/video pin output stage for the TinyTapeout top level. It takes pixel colour, sync and audio samples from `demo_top`-class generators and drives the TinyVGA PMOD on `uo_out` and a single audio pin on `uio_out[7]`. Unlike the fixed rgb222 mapping, it accepts wider colour with 2×2 ordered dithering down to 2 bits per channel, forces blanking, and converts a multi-bit audio sample to a 1-bit first-order sigma-delta stream. All pin outputs are retimed through a configurable register pipeline.

## Interface
- `COLOR_BITS`, 2: bits per colour channel in; legal 2..4.
- `AUDIO_BITS`, 8: audio sample width; legal 4..16.
- `PIPE_STAGES`, 1: output register stages; legal 1..4.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rgb`  in  3*COLOR_BITS  `{r,g,b}`, MSB-first per channel.
- `active`  in  1  high during visible pixels.
- `hsync`  in  1  horizontal sync, passed through unmodified (polarity unchanged).
- `vsync`  in  1  vertical sync, passed through unmodified.
- `new_frame`  in  1  one-cycle pulse at frame start.
- `dither_en`  in  1  1 = ordered dither; 0 = truncate to top 2 bits.
- `audio_sample`  in  AUDIO_BITS  unsigned PCM sample.
- `audio_valid`  in  1  load `audio_sample` this cycle.
- `uo_out`  out  8  `{hsync,b0,g0,r0,vsync,b1,g1,r1}`.
- `uio_out`  out  8  `[7]` = PDM audio; `[6:0]` = 0.
- `uio_oe`  out  8  constant 8'h80.

## Operation
- Blanking: when `active`=0, all six colour bits are 0 before pipelining. Syncs are never blanked.
- Position parity:
  - `xp` toggles every cycle with `active`=1 and clears to 0 in any cycle with `active`=0.
  - `yp` toggles on each falling edge of `active` (registered `active`=1, current `active`=0).
  - `yp` clears on `new_frame`. If `new_frame` and a falling edge coincide, clear wins.
- Dither, per channel, for COLOR_BITS > 2:
  - `top` = 2 MSBs.
  - `frac` = remaining E = COLOR_BITS-2 bits, left-aligned into 2 bits (zero-padded).
  - Threshold `t` by (xp,yp): (0,0)=0, (1,0)=2, (0,1)=3, (1,1)=1.
  - Output = `top` + (`frac` > `t`), saturating at 3.
  - With `dither_en`=0, output = `top`. With COLOR_BITS=2, the input passes straight through.
  - Dither uses the `xp`/`yp` register values of the current cycle, before their update.
- Audio:
  - `sample_q` (AUDIO_BITS) loads on `audio_valid`.
  - Accumulator `acc` (AUDIO_BITS): every cycle `{carry, acc} <= acc + sample_q`.
  - Registered `pdm_bit <= carry`.
  - A newly loaded sample affects the sum starting the following cycle.
  - Duty = `sample_q` / 2^AUDIO_BITS. Sample 0 gives constant 0; the all-ones sample gives 1 except one 0 per 2^AUDIO_BITS cycles.
- Pipeline:
  - Stage 0 input = {mapped `uo_out` byte, `pdm_bit`}. It is delayed through PIPE_STAGES registers.
  - The final stage drives `uo_out` and `uio_out[7]`.
  - `uio_oe` and `uio_out[6:0]` are constants, not registered.

## Timing
- Video latency: inputs at cycle n appear on `uo_out` at n+PIPE_STAGES. Syncs and colour stay aligned at every setting.
- Audio latency: a carry computed at cycle n reaches `pdm_bit` at n+1 and `uio_out[7]` at n+1+PIPE_STAGES.
- Reset (synchronous) clears all pipeline registers, `xp`, `yp`, `acc`, `sample_q` and `pdm_bit`.
  - `uo_out` = 8'h00 and `uio_out` = 8'h00 from the first clock edge with `reset` high.
  - Reset mid-line clears everything that cycle. The first non-reset output appears PIPE_STAGES cycles after reset deasserts.
- `audio_valid` in the same cycle as `reset` is ignored.
- `acc` wraps modulo 2^AUDIO_BITS. Carry is the overflow bit only.

## Test plan
- Pinout/latency, COLOR_BITS=2, PIPE_STAGES=3: set rgb=6'b10_01_11, active=1, hsync=1, vsync=0 for one cycle → 3 cycles later `uo_out`=8'b1_1_1_0_0_1_0_1; `uio_oe`=8'h80 at all times.
- Blanking: rgb=all ones, active=0, vsync=1 → `uo_out`=8'h08.
- Dither, COLOR_BITS=4, r=4'b0110, g=b=0, two active lines of 2 pixels:
  - line 0 r = 2,1; line 1 r = 1,2.
  - r=4'b1111 → 3 everywhere.
  - With dither_en=0 → r=1 for all four pixels.
- Parity reset: assert `new_frame` together with a falling edge of `active` → next line uses yp=0 thresholds (0,2).
- Audio, AUDIO_BITS=8: load 128 → `uio_out[7]` alternates 0,1 after latency; load 64 → one 1 per 4 cycles; load 0 → constant 0.
- Reset mid-operation: assert `reset` during active video and audio streaming → outputs are 0 the next cycle. After release, `acc` restarts from 0: sample 128 gives first 1 on the second post-reset sum.
